snes_mem_arbiter: RTL and testbench

- Shares one external SDRAM controller command port between three SNES memory requesters: cartridge ROM/BSRAM (CPU bus), Work RAM (SWRAM RAM_* side) and Audio RAM (DSP RAM_* side).
- Sits between the SNES top level and the SDRAM controller.
- Captures single-cycle requests, arbitrates with fixed priority plus CPU anti-starvation, maps each requester into its SDRAM region, and returns read data with a done pulse.

---
 rtl/snes_mem_arbiter_if.sv | 21 ++
 rtl/snes_mem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_snes_mem_arbiter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snes_mem_arbiter_if.sv
// SDRAM controller command port shared by the SNES memory requesters.
// The arbiter drives the command side (master); the SDRAM controller
// answers with read data and a one-cycle acknowledge (slave).
interface snes_mem_arbiter_if;
  logic        mem_req;   // command valid, held until mem_ack
  logic [22:0] mem_addr;  // SDRAM byte address
  logic        mem_we;    // 1 = write
  logic [7:0]  mem_din;   // write data
  logic [7:0]  mem_dout;  // read data, valid with mem_ack
  logic        mem_ack;   // one-cycle completion

  modport master (
    output mem_req, mem_addr, mem_we, mem_din,
    input  mem_dout, mem_ack
  );

  modport slave (
    input  mem_req, mem_addr, mem_we, mem_din,
    output mem_dout, mem_ack
  );
endinterface

// File: rtl/snes_mem_arbiter.sv
// Three-way SNES memory arbiter in front of a single SDRAM command port.
// Requesters: cartridge ROM/BSRAM (CPU bus), Work RAM and Audio RAM.
// Each requester owns one capture slot. A one-cycle request strobe fills the
// slot; the arbiter grants one slot at a time (ARAM > WRAM > CPU, with the CPU
// promoted after MAX_SKIP lost arbitrations), maps it into its SDRAM region,
// holds the command until mem_ack (or a timeout) and then returns the read
// data with a one-cycle rdy pulse.
module snes_mem_arbiter #(
  parameter logic [22:0] WRAM_BASE = 23'h600000,
  parameter logic [22:0] ARAM_BASE = 23'h620000,
  parameter int unsigned MAX_SKIP  = 4,
  parameter int unsigned TIMEOUT   = 63
) (
  input  logic               WCLK,
  input  logic               RST_N,

  // Cartridge ROM/BSRAM requester (CPU bus)
  input  logic               cpu_req,
  input  logic [21:0]        cpu_addr,
  input  logic               cpu_we,
  input  logic [7:0]         cpu_din,
  output logic [7:0]         cpu_dout,
  output logic               cpu_rdy,

  // Work RAM requester
  input  logic               wram_req,
  input  logic               wram_we,
  input  logic [16:0]        wram_addr,
  input  logic [7:0]         wram_din,
  output logic [7:0]         wram_dout,
  output logic               wram_rdy,

  // Audio RAM requester
  input  logic               aram_req,
  input  logic               aram_we,
  input  logic [15:0]        aram_addr,
  input  logic [7:0]         aram_din,
  output logic [7:0]         aram_dout,
  output logic               aram_rdy,

  // SDRAM controller command port
  snes_mem_arbiter_if.master sdram,

  // Sticky error flags {timeout, overrun_wram_or_aram, overrun_cpu}
  output logic [2:0]         err,
  input  logic               err_clr
);

  // ---------------------------------------------------------------------------
  // Encodings
  // ---------------------------------------------------------------------------
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] SLOT_CPU  = 2'd0;
  localparam logic [1:0] SLOT_WRAM = 2'd1;
  localparam logic [1:0] SLOT_ARAM = 2'd2;

  localparam int unsigned   TW       = $clog2(TIMEOUT + 1);
  // The counter starts at 0 on the first WAIT cycle, so the last permitted
  // WAIT cycle is TIMEOUT-1; mem_req is therefore high for TIMEOUT cycles.
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [2:0]    SKIP_MAX = 3'(MAX_SKIP);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]    state;
  logic [1:0]    gnt;        // slot currently in WAIT/DONE
  logic [2:0]    skip_cnt;   // arbitrations the pending CPU has lost in a row
  logic [TW-1:0] tmo_cnt;

  // Capture slots: pending bit plus the already-mapped command
  logic          cpu_pend,  wram_pend,  aram_pend;
  logic [22:0]   cpu_slot_addr, wram_slot_addr, aram_slot_addr;
  logic          cpu_slot_we,   wram_slot_we,   aram_slot_we;
  logic [7:0]    cpu_slot_din,  wram_slot_din,  aram_slot_din;

  // ---------------------------------------------------------------------------
  // Request capture qualification
  // ---------------------------------------------------------------------------
  logic in_wait;
  logic cpu_busy, wram_busy, aram_busy;
  logic cpu_take, wram_take, aram_take;
  logic cpu_ovr,  wram_ovr,  aram_ovr;

  assign in_wait = (state == S_WAIT);

  // A slot is busy while it waits for a grant or while it is being served.
  // In DONE the pending bit is already clear, so a new strobe is accepted.
  assign cpu_busy  = cpu_pend  | (in_wait & (gnt == SLOT_CPU));
  assign wram_busy = wram_pend | (in_wait & (gnt == SLOT_WRAM));
  assign aram_busy = aram_pend | (in_wait & (gnt == SLOT_ARAM));

  assign cpu_take  = cpu_req  & ~cpu_busy;
  assign wram_take = wram_req & ~wram_busy;
  assign aram_take = aram_req & ~aram_busy;

  assign cpu_ovr   = cpu_req  & cpu_busy;
  assign wram_ovr  = wram_req & wram_busy;
  assign aram_ovr  = aram_req & aram_busy;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic        any_pend;
  logic        cpu_starved;
  logic        do_grant;
  logic [1:0]  pick;
  logic [22:0] pick_addr;
  logic        pick_we;
  logic [7:0]  pick_din;

  assign any_pend    = cpu_pend | wram_pend | aram_pend;
  assign cpu_starved = cpu_pend & (skip_cnt == SKIP_MAX);
  assign do_grant    = (state == S_IDLE) & any_pend;

  // Winner selection: promoted CPU first, otherwise ARAM > WRAM > CPU
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no
    // path leaves it unassigned; that is what keeps a latch from being inferred.
    pick = SLOT_CPU;
    if (cpu_starved)    pick = SLOT_CPU;
    else if (aram_pend) pick = SLOT_ARAM;
    else if (wram_pend) pick = SLOT_WRAM;
  end

  // Command of the winning slot
  always_comb begin
    pick_addr = cpu_slot_addr;
    pick_we   = cpu_slot_we;
    pick_din  = cpu_slot_din;
    case (pick)
      SLOT_WRAM: begin
        pick_addr = wram_slot_addr;
        pick_we   = wram_slot_we;
        pick_din  = wram_slot_din;
      end
      SLOT_ARAM: begin
        pick_addr = aram_slot_addr;
        pick_we   = aram_slot_we;
        pick_din  = aram_slot_din;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Completion
  // ---------------------------------------------------------------------------
  logic tmo_hit;
  logic finish;

  // An ack in the last permitted cycle still counts as a normal completion.
  assign tmo_hit = in_wait & ~sdram.mem_ack & (tmo_cnt == TMO_LAST);
  assign finish  = in_wait & (sdram.mem_ack | (tmo_cnt == TMO_LAST));

  // ---------------------------------------------------------------------------
  // Slot pending bits: set on an accepted strobe, cleared when granted
  // ---------------------------------------------------------------------------
  // Pending bits for all three requesters
  always_ff @(posedge WCLK or negedge RST_N) begin
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    if (!RST_N) begin
      cpu_pend  <= 1'b0;
      wram_pend <= 1'b0;
      aram_pend <= 1'b0;
    end else begin
      if (cpu_take)                           cpu_pend  <= 1'b1;
      else if (do_grant && pick == SLOT_CPU)  cpu_pend  <= 1'b0;

      if (wram_take)                          wram_pend <= 1'b1;
      else if (do_grant && pick == SLOT_WRAM) wram_pend <= 1'b0;

      if (aram_take)                          aram_pend <= 1'b1;
      else if (do_grant && pick == SLOT_ARAM) aram_pend <= 1'b0;
    end
  end

  // Slot payload capture with the region mapping applied up front
  always_ff @(posedge WCLK) begin
    // NOTE: the payload has no reset; it is only read while its pending bit is
    // set, and that bit is only set by the same edge that loads the payload.
    if (cpu_take) begin
      cpu_slot_addr  <= {1'b0, cpu_addr};
      cpu_slot_we    <= cpu_we;
      cpu_slot_din   <= cpu_din;
    end
    if (wram_take) begin
      wram_slot_addr <= WRAM_BASE + {6'd0, wram_addr};
      wram_slot_we   <= wram_we;
      wram_slot_din  <= wram_din;
    end
    if (aram_take) begin
      aram_slot_addr <= ARAM_BASE + {7'd0, aram_addr};
      aram_slot_we   <= aram_we;
      aram_slot_din  <= aram_din;
    end
  end

  // ---------------------------------------------------------------------------
  // Main FSM and SDRAM command registers
  // ---------------------------------------------------------------------------
  // IDLE grants a slot, WAIT holds the command until ack/timeout, DONE pulses rdy
  always_ff @(posedge WCLK or negedge RST_N) begin
    if (!RST_N) begin
      state          <= S_IDLE;
      gnt            <= SLOT_CPU;
      sdram.mem_req  <= 1'b0;
      sdram.mem_addr <= 23'd0;
      sdram.mem_we   <= 1'b0;
      sdram.mem_din  <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (do_grant) begin
            gnt            <= pick;
            sdram.mem_req  <= 1'b1;
            sdram.mem_addr <= pick_addr;
            sdram.mem_we   <= pick_we;
            sdram.mem_din  <= pick_din;
            state          <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (finish) begin
            sdram.mem_req <= 1'b0;
            state         <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // WAIT-cycle counter, restarted on every grant
  always_ff @(posedge WCLK or negedge RST_N) begin
    if (!RST_N)       tmo_cnt <= '0;
    else if (do_grant) tmo_cnt <= '0;
    else if (in_wait && !finish) tmo_cnt <= tmo_cnt + 1'b1;
  end

  // CPU anti-starvation counter: counts grants lost while the CPU waits
  always_ff @(posedge WCLK or negedge RST_N) begin
    if (!RST_N) begin
      skip_cnt <= 3'd0;
    end else if (do_grant) begin
      if (pick == SLOT_CPU || !cpu_pend) skip_cnt <= 3'd0;
      else if (skip_cnt != SKIP_MAX)     skip_cnt <= skip_cnt + 3'd1;
    end else if (!cpu_pend) begin
      skip_cnt <= 3'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // Read data return
  // ---------------------------------------------------------------------------
  logic [7:0] ret_data;
  assign ret_data = sdram.mem_ack ? sdram.mem_dout : 8'hFF;

  // Reads update the granted requester's dout; writes leave it untouched
  always_ff @(posedge WCLK or negedge RST_N) begin
    if (!RST_N) begin
      cpu_dout  <= 8'hFF;
      wram_dout <= 8'hFF;
      aram_dout <= 8'hFF;
    end else if (finish && !sdram.mem_we) begin
      case (gnt)
        SLOT_CPU:  cpu_dout  <= ret_data;
        SLOT_WRAM: wram_dout <= ret_data;
        SLOT_ARAM: aram_dout <= ret_data;
        default: ;
      endcase
    end
  end

  // DONE lasts exactly one cycle, so rdy is a one-cycle pulse to one requester
  assign cpu_rdy  = (state == S_DONE) & (gnt == SLOT_CPU);
  assign wram_rdy = (state == S_DONE) & (gnt == SLOT_WRAM);
  assign aram_rdy = (state == S_DONE) & (gnt == SLOT_ARAM);

  // ---------------------------------------------------------------------------
  // Sticky error flags
  // ---------------------------------------------------------------------------
  // A new error in the same cycle as err_clr survives the clear
  always_ff @(posedge WCLK or negedge RST_N) begin
    if (!RST_N) err <= 3'b000;
    else        err <= (err & ~{3{err_clr}}) | {tmo_hit, wram_ovr | aram_ovr, cpu_ovr};
  end

endmodule

// File: tb/tb_snes_mem_arbiter.sv
// Self-checking bench for snes_mem_arbiter.
// A transaction-level model (per-requester pending flags, one active access,
// edge timestamps) predicts every output after every clock edge; directed
// sections pin the model with hand-computed literals, then a randomized
// section exercises mixed traffic, write/read mixes, timeouts and err_clr.
module tb_snes_mem_arbiter;

  localparam int TIMEOUT  = 63;
  localparam int MAX_SKIP = 4;
  localparam int P_CPU    = 0;
  localparam int P_WRAM   = 1;
  localparam int P_ARAM   = 2;

  logic        WCLK = 1'b0;
  logic        RST_N = 1'b0;

  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [21:0] cpu_addr = '0;
  logic [7:0]  cpu_din = '0;
  logic [7:0]  cpu_dout;
  logic        cpu_rdy;

  logic        wram_req = 1'b0, wram_we = 1'b0;
  logic [16:0] wram_addr = '0;
  logic [7:0]  wram_din = '0;
  logic [7:0]  wram_dout;
  logic        wram_rdy;

  logic        aram_req = 1'b0, aram_we = 1'b0;
  logic [15:0] aram_addr = '0;
  logic [7:0]  aram_din = '0;
  logic [7:0]  aram_dout;
  logic        aram_rdy;

  logic [2:0]  err;
  logic        err_clr = 1'b0;

  snes_mem_arbiter_if sdram();

  snes_mem_arbiter dut (
    .WCLK      (WCLK),
    .RST_N     (RST_N),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_we    (cpu_we),
    .cpu_din   (cpu_din),
    .cpu_dout  (cpu_dout),
    .cpu_rdy   (cpu_rdy),
    .wram_req  (wram_req),
    .wram_we   (wram_we),
    .wram_addr (wram_addr),
    .wram_din  (wram_din),
    .wram_dout (wram_dout),
    .wram_rdy  (wram_rdy),
    .aram_req  (aram_req),
    .aram_we   (aram_we),
    .aram_addr (aram_addr),
    .aram_din  (aram_din),
    .aram_dout (aram_dout),
    .aram_rdy  (aram_rdy),
    .sdram     (sdram),
    .err       (err),
    .err_clr   (err_clr)
  );

  always #5 WCLK = ~WCLK;

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int   n_checks = 0;
  int   n_errs   = 0;
  int   ack_pct  = 0;
  logic prev_req = 1'b0;
  int   grants[$];
  int   rdys[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  bit          m_pend[3];
  logic [22:0] m_addr[3];
  bit          m_we[3];
  logic [7:0]  m_din[3];
  logic [7:0]  m_dout[3];
  int          m_active;      // port being served, -1 when none
  int          m_grant_edge;
  int          m_free_edge;   // first edge at which a new grant may happen
  int          m_rdy;         // port whose rdy is high after this edge, -1 none
  int          m_losses;
  int          edge_n;
  logic [22:0] m_maddr;
  logic        m_mwe;
  logic [7:0]  m_mdin;
  logic [2:0]  m_err;

  task automatic model_reset();
    for (int p = 0; p < 3; p++) begin
      m_pend[p] = 1'b0;
      m_dout[p] = 8'hFF;
    end
    m_active = -1; m_grant_edge = 0; m_free_edge = 0; m_rdy = -1;
    m_losses = 0;  edge_n = 0;
    m_maddr = '0; m_mwe = 1'b0; m_mdin = '0; m_err = '0;
  endtask

  // Advance the model over one clock edge using the inputs present at that edge
  task automatic model_step();
    bit         req[3];
    bit         take[3];
    bit         busy;
    bit         granted;
    bit         cpu_pre;
    logic [2:0] set_err;
    int         w;
    req[P_CPU] = cpu_req; req[P_WRAM] = wram_req; req[P_ARAM] = aram_req;
    edge_n++;
    set_err = '0;
    granted = 1'b0;
    cpu_pre = m_pend[P_CPU];

    for (int p = 0; p < 3; p++) begin
      busy    = m_pend[p] || (m_active == p);
      take[p] = req[p] && !busy;
      if (req[p] && busy) begin
        if (p == P_CPU) set_err[0] = 1'b1;
        else            set_err[1] = 1'b1;
      end
    end

    m_rdy = -1;
    if (m_active >= 0) begin
      if (sdram.mem_ack || (edge_n - m_grant_edge >= TIMEOUT)) begin
        if (!sdram.mem_ack) set_err[2] = 1'b1;
        if (!m_mwe) m_dout[m_active] = sdram.mem_ack ? sdram.mem_dout : 8'hFF;
        m_rdy       = m_active;
        m_active    = -1;
        m_free_edge = edge_n + 2;
      end
    end else if (edge_n >= m_free_edge && (m_pend[0] || m_pend[1] || m_pend[2])) begin
      if (cpu_pre && m_losses >= MAX_SKIP) w = P_CPU;
      else if (m_pend[P_ARAM])             w = P_ARAM;
      else if (m_pend[P_WRAM])             w = P_WRAM;
      else                                 w = P_CPU;
      if (w == P_CPU || !cpu_pre) m_losses = 0;
      else if (m_losses < MAX_SKIP) m_losses++;
      m_maddr      = m_addr[w];
      m_mwe        = m_we[w];
      m_mdin       = m_din[w];
      m_pend[w]    = 1'b0;
      m_active     = w;
      m_grant_edge = edge_n;
      granted      = 1'b1;
    end
    if (!granted && !cpu_pre) m_losses = 0;

    if (take[P_CPU]) begin
      m_pend[P_CPU] = 1'b1; m_addr[P_CPU] = {1'b0, cpu_addr};
      m_we[P_CPU] = cpu_we; m_din[P_CPU] = cpu_din;
    end
    if (take[P_WRAM]) begin
      m_pend[P_WRAM] = 1'b1; m_addr[P_WRAM] = 23'h600000 + 23'(wram_addr);
      m_we[P_WRAM] = wram_we; m_din[P_WRAM] = wram_din;
    end
    if (take[P_ARAM]) begin
      m_pend[P_ARAM] = 1'b1; m_addr[P_ARAM] = 23'h620000 + 23'(aram_addr);
      m_we[P_ARAM] = aram_we; m_din[P_ARAM] = aram_din;
    end

    m_err = (m_err & ~{3{err_clr}}) | set_err;
  endtask

  function automatic int port_of(input logic [22:0] a);
    if (a >= 23'h620000 && a < 23'h630000) return P_ARAM;
    if (a >= 23'h600000 && a < 23'h620000) return P_WRAM;
    return P_CPU;
  endfunction

  // Compare every DUT output against the model
  task automatic compare();
    int nrdy;
    nrdy = int'(cpu_rdy) + int'(wram_rdy) + int'(aram_rdy);
    check("mem_req",   32'(sdram.mem_req),  32'(m_active >= 0));
    check("mem_addr",  32'(sdram.mem_addr), 32'(m_maddr));
    check("mem_we",    32'(sdram.mem_we),   32'(m_mwe));
    check("mem_din",   32'(sdram.mem_din),  32'(m_mdin));
    check("cpu_rdy",   32'(cpu_rdy),        32'(m_rdy == P_CPU));
    check("wram_rdy",  32'(wram_rdy),       32'(m_rdy == P_WRAM));
    check("aram_rdy",  32'(aram_rdy),       32'(m_rdy == P_ARAM));
    check("cpu_dout",  32'(cpu_dout),       32'(m_dout[P_CPU]));
    check("wram_dout", 32'(wram_dout),      32'(m_dout[P_WRAM]));
    check("aram_dout", 32'(aram_dout),      32'(m_dout[P_ARAM]));
    check("err",       32'(err),            32'(m_err));
    check("one_rdy",   32'(nrdy <= 1),      32'd1);
  endtask

  // One clock: model + compare after the edge, then default next-edge inputs
  task automatic cycle();
    @(posedge WCLK);
    #1;
    if (!RST_N) model_reset();
    else        model_step();
    compare();
    if (!prev_req && sdram.mem_req) grants.push_back(port_of(sdram.mem_addr));
    prev_req = sdram.mem_req;
    if (cpu_rdy)  rdys.push_back(P_CPU);
    if (wram_rdy) rdys.push_back(P_WRAM);
    if (aram_rdy) rdys.push_back(P_ARAM);
    cpu_req = 1'b0; wram_req = 1'b0; aram_req = 1'b0; err_clr = 1'b0;
    sdram.mem_ack  = RST_N && sdram.mem_req && ($urandom_range(0, 99) < ack_pct);
    sdram.mem_dout = 8'($urandom);
  endtask

  // Run until the model reports no pending or active work
  task automatic drain();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 2000 && !idle; i++) begin
      cycle();
      idle = !m_pend[0] && !m_pend[1] && !m_pend[2] && m_active < 0 && m_rdy < 0;
    end
    check("drain_idle", 32'(idle), 32'd1);
    cycle();
  endtask

  task automatic rand_inputs();
    if ($urandom_range(0, 5) == 0) begin
      cpu_req = 1'b1; cpu_addr = 22'($urandom); cpu_we = 1'($urandom); cpu_din = 8'($urandom);
    end
    if ($urandom_range(0, 5) == 0) begin
      wram_req = 1'b1; wram_addr = 17'($urandom); wram_we = 1'($urandom); wram_din = 8'($urandom);
    end
    if ($urandom_range(0, 5) == 0) begin
      aram_req = 1'b1; aram_addr = 16'($urandom); aram_we = 1'($urandom); aram_din = 8'($urandom);
    end
    err_clr = ($urandom_range(0, 19) == 0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int hi_cnt;
    int rdy_cnt;
    bit seen;
    int seg_pct[4];
    seg_pct[0] = 50; seg_pct[1] = 10; seg_pct[2] = 2; seg_pct[3] = 30;
    sdram.mem_ack  = 1'b0;
    sdram.mem_dout = 8'h00;

    // Reset state
    cycle();
    cycle();
    RST_N = 1'b1;
    check("rst_mem_req",  32'(sdram.mem_req),  32'd0);
    check("rst_mem_addr", 32'(sdram.mem_addr), 32'd0);
    check("rst_aram_dout", 32'(aram_dout),     32'hFF);
    check("rst_err",      32'(err),            32'd0);

    // Single ARAM read
    aram_req = 1'b1; aram_addr = 16'h1234; aram_we = 1'b0;
    cycle();
    check("aram_req_k", 32'(sdram.mem_req), 32'd0);
    cycle();
    check("aram_req_k1",  32'(sdram.mem_req),  32'd1);
    check("aram_addr_k1", 32'(sdram.mem_addr), 32'h621234);
    sdram.mem_ack = 1'b1; sdram.mem_dout = 8'h5A;
    cycle();
    check("aram_rdy_pulse", 32'(aram_rdy),  32'd1);
    check("aram_dout_5a",   32'(aram_dout), 32'h5A);
    cycle();
    check("aram_rdy_drop",  32'(aram_rdy),  32'd0);
    drain();

    // Three simultaneous reads: ARAM, WRAM, CPU
    ack_pct = 30;
    rdys.delete();
    cpu_req = 1'b1;  cpu_addr = 22'h012345; cpu_we = 1'b0;
    wram_req = 1'b1; wram_addr = 17'h00ABC; wram_we = 1'b0;
    aram_req = 1'b1; aram_addr = 16'h0F0F;  aram_we = 1'b0;
    for (int i = 0; i < 600 && rdys.size() < 3; i++) cycle();
    check("order_cnt", 32'(rdys.size()), 32'd3);
    if (rdys.size() == 3) begin
      check("order_0", 32'(rdys[0]), 32'(P_ARAM));
      check("order_1", 32'(rdys[1]), 32'(P_WRAM));
      check("order_2", 32'(rdys[2]), 32'(P_CPU));
    end
    drain();

    // CPU anti-starvation against a re-requesting ARAM
    ack_pct = 50;
    grants.delete();
    cpu_req = 1'b1;  cpu_addr = 22'h000100; cpu_we = 1'b0;
    wram_req = 1'b1; wram_addr = 17'h00200; wram_we = 1'b0;
    aram_req = 1'b1; aram_addr = 16'h0300;  aram_we = 1'b0;
    for (int i = 0; i < 2000 && grants.size() < 6; i++) begin
      cycle();
      if (aram_rdy && grants.size() < 5) begin
        aram_req = 1'b1; aram_addr = 16'($urandom); aram_we = 1'b0;
      end
    end
    check("starve_cnt", 32'(grants.size() >= 6), 32'd1);
    if (grants.size() >= 6) begin
      for (int i = 0; i < 4; i++) check("starve_lose", 32'(grants[i]), 32'(P_ARAM));
      check("starve_cpu",   32'(grants[4]), 32'(P_CPU));
      check("starve_after", 32'(grants[5]), 32'(P_ARAM));
    end
    drain();

    // WRAM read to establish a known dout, then a WRAM write
    ack_pct = 0;
    wram_req = 1'b1; wram_addr = 17'h00010; wram_we = 1'b0;
    cycle(); cycle();
    sdram.mem_ack = 1'b1; sdram.mem_dout = 8'h77;
    cycle();
    check("wram_rd_dout", 32'(wram_dout), 32'h77);
    drain();
    wram_req = 1'b1; wram_addr = 17'h1FFFF; wram_we = 1'b1; wram_din = 8'hC3;
    cycle(); cycle();
    check("wram_wr_addr", 32'(sdram.mem_addr), 32'h61FFFF);
    check("wram_wr_we",   32'(sdram.mem_we),   32'd1);
    check("wram_wr_din",  32'(sdram.mem_din),  32'hC3);
    sdram.mem_ack = 1'b1; sdram.mem_dout = 8'h99;
    cycle();
    check("wram_wr_rdy",  32'(wram_rdy),  32'd1);
    check("wram_wr_keep", 32'(wram_dout), 32'h77);
    drain();

    // CPU read with data, then a CPU read that times out
    cpu_req = 1'b1; cpu_addr = 22'h3FFFFF; cpu_we = 1'b0;
    cycle(); cycle();
    sdram.mem_ack = 1'b1; sdram.mem_dout = 8'h3C;
    cycle();
    check("cpu_rd_dout", 32'(cpu_dout), 32'h3C);
    drain();
    cpu_req = 1'b1; cpu_addr = 22'h000042; cpu_we = 1'b0;
    cycle();
    hi_cnt = 0; rdy_cnt = 0; seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      cycle();
      if (sdram.mem_req) hi_cnt++;
      if (cpu_rdy) begin rdy_cnt++; seen = 1'b1; end
    end
    check("tmo_req_cycles", 32'(hi_cnt),   32'd63);
    check("tmo_err",        32'(err),      32'b100);
    check("tmo_dout",       32'(cpu_dout), 32'hFF);
    cycle();
    if (cpu_rdy) rdy_cnt++;
    check("tmo_rdy_once",   32'(rdy_cnt),  32'd1);
    err_clr = 1'b1;
    cycle();
    check("err_clr", 32'(err), 32'd0);
    drain();

    // CPU overrun while in WAIT, then reset mid-WAIT
    cpu_req = 1'b1; cpu_addr = 22'h001000; cpu_we = 1'b0;
    cycle(); cycle();
    cpu_req = 1'b1; cpu_addr = 22'h002000;
    cycle();
    check("ovr_err", 32'(err), 32'b001);
    cycle(); cycle();
    RST_N = 1'b0;
    #1;
    check("rst_mid_req", 32'(sdram.mem_req), 32'd0);
    check("rst_mid_err", 32'(err),           32'd0);
    cycle(); cycle();
    RST_N = 1'b1;
    rdy_cnt = 0;
    for (int i = 0; i < 80; i++) begin
      cycle();
      if (cpu_rdy) rdy_cnt++;
    end
    check("rst_no_rdy", 32'(rdy_cnt), 32'd0);

    // Randomized traffic with varying SDRAM responsiveness
    for (int s = 0; s < 4; s++) begin
      ack_pct = seg_pct[s];
      for (int i = 0; i < 500; i++) begin
        cycle();
        rand_inputs();
      end
    end
    ack_pct = 40;
    drain();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  // Hard stop if the stimulus ever stalls
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errs);
    $fatal(1);
  end

endmodule
